// File: rtl/simplez_pkg.sv
// Shared constants and TX state encoding for the Simplez bus responder.
package simplez_pkg;

  localparam int DATAW            = 12;
  localparam int ADDRW            = 9;
  localparam int IO_BASE          = 508;
  localparam int DEFAULT_BAUD_DIV = 104;

  localparam logic [ADDRW-1:0] ADDR_RSVD   = ADDRW'(IO_BASE);
  localparam logic [ADDRW-1:0] ADDR_LEDS   = ADDRW'(IO_BASE + 1);
  localparam logic [ADDRW-1:0] ADDR_TXSTAT = ADDRW'(IO_BASE + 2);
  localparam logic [ADDRW-1:0] ADDR_TXDATA = ADDRW'(IO_BASE + 3);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/simplez_uart_tx.sv
// Serial transmitter, 8N1 by default; SIMPLEZ_TX_PARITY_EN inserts an even parity bit.
module simplez_uart_tx
  import simplez_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

  tx_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             ready_reg;
`ifdef SIMPLEZ_TX_PARITY_EN
  logic             parity_reg;
`endif

  assign tx    = tx_reg;
  assign ready = ready_reg;

  // tx is driven from a register, so each bit's level is set on the edge that enters it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= TX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      ready_reg   <= 1'b1;
`ifdef SIMPLEZ_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        TX_IDLE: begin
          tx_reg <= 1'b1;
          if (start) begin
            state_reg <= TX_START;
            tx_reg    <= 1'b0;
            ready_reg <= 1'b0;
            shift_reg <= data;
            cnt_reg   <= RELOAD;
`ifdef SIMPLEZ_TX_PARITY_EN
            parity_reg <= ^data;
`endif
          end
        end
        TX_START: begin
          if (cnt_reg == '0) begin
            state_reg   <= TX_DATA;
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_idx_reg <= '0;
            cnt_reg     <= RELOAD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        TX_DATA: begin
          if (cnt_reg == '0) begin
            cnt_reg <= RELOAD;
            if (bit_idx_reg == 3'd7) begin
`ifdef SIMPLEZ_TX_PARITY_EN
              state_reg <= TX_PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= TX_STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
`ifdef SIMPLEZ_TX_PARITY_EN
        TX_PARITY: begin
          if (cnt_reg == '0) begin
            state_reg <= TX_STOP;
            tx_reg    <= 1'b1;
            cnt_reg   <= RELOAD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (cnt_reg == '0) begin
            state_reg <= TX_IDLE;
            ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= TX_IDLE;
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/simplez_bus_slave.sv
// Simplez memory-bus responder: RAM below IO_BASE, LED/UART registers above.
// Build with SIMPLEZ_TX_PARITY_EN to add an even parity bit to each serial frame.
module simplez_bus_slave #(
  parameter int DATAW    = simplez_pkg::DATAW,
  parameter int ADDRW    = simplez_pkg::ADDRW,
  parameter int LEDW     = 3,
  parameter int BAUD_DIV = simplez_pkg::DEFAULT_BAUD_DIV,
  parameter int IO_BASE  = simplez_pkg::IO_BASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] wdata,
  input  logic             rd,
  input  logic             wr,
  output logic [DATAW-1:0] rdata,
  output logic [LEDW-1:0]  leds,
  output logic             tx
);

  localparam logic [ADDRW-1:0] A_IO     = ADDRW'(IO_BASE);
  localparam logic [ADDRW-1:0] A_LEDS   = ADDRW'(IO_BASE + 1);
  localparam logic [ADDRW-1:0] A_TXSTAT = ADDRW'(IO_BASE + 2);
  localparam logic [ADDRW-1:0] A_TXDATA = ADDRW'(IO_BASE + 3);

  logic [DATAW-1:0] ram [IO_BASE];
  logic [DATAW-1:0] rdata_reg;
  logic [LEDW-1:0]  led_reg;
  logic [7:0]       last_byte_reg;
  logic             overrun_reg;
  logic             tx_ready;

  logic in_ram;
  logic rd_only;
  logic tx_accept;
  logic tx_drop;
  logic stat_read;

  assign in_ram    = (addr < A_IO);
  assign rd_only   = rd && !wr;
  assign tx_accept = wr && (addr == A_TXDATA) && tx_ready;
  assign tx_drop   = wr && (addr == A_TXDATA) && !tx_ready;
  assign stat_read = rd_only && (addr == A_TXSTAT);

  assign rdata = rdata_reg;
  assign leds  = led_reg;

  always_ff @(posedge clk) begin
    if (wr && in_ram) begin
      ram[addr] <= wdata;
    end
  end

  // A combined rd+wr strobe is treated purely as a write, so rdata holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (rd_only) begin
      if (in_ram) begin
        rdata_reg <= ram[addr];
      end else begin
        case (addr)
          A_LEDS:   rdata_reg <= DATAW'(led_reg);
          A_TXSTAT: rdata_reg <= DATAW'({overrun_reg, tx_ready});
          A_TXDATA: rdata_reg <= DATAW'(last_byte_reg);
          default:  rdata_reg <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg       <= '0;
      last_byte_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      if (wr && (addr == A_LEDS)) begin
        led_reg <= wdata[LEDW-1:0];
      end
      if (tx_accept) begin
        last_byte_reg <= wdata[7:0];
      end
      // Setting takes priority over the read-to-clear.
      if (tx_drop) begin
        overrun_reg <= 1'b1;
      end else if (stat_read) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  simplez_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_accept),
    .data (wdata[7:0]),
    .ready(tx_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_simplez_bus_slave.sv
// Directed bench for simplez_bus_slave with BAUD_DIV=4; honours SIMPLEZ_TX_PARITY_EN.
module tb_simplez_bus_slave;

  localparam int DATAW = 12;
  localparam int ADDRW = 9;
  localparam int LEDW  = 3;
  localparam int BAUD  = 4;
`ifdef SIMPLEZ_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam logic [10:0] WAVE_41 = 11'b10010000010;
`else
  localparam int FRAME_BITS = 10;
  localparam logic [10:0] WAVE_41 = 11'b01010000010;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ADDRW-1:0] addr = '0;
  logic [DATAW-1:0] wdata = '0;
  logic             rd = 1'b0;
  logic             wr = 1'b0;
  logic [DATAW-1:0] rdata;
  logic [LEDW-1:0]  leds;
  logic             tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simplez_bus_slave #(
    .DATAW(DATAW), .ADDRW(ADDRW), .LEDW(LEDW), .BAUD_DIV(BAUD), .IO_BASE(508)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
    .rdata(rdata), .leds(leds), .tx(tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    wr = 1'b1; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [ADDRW-1:0] a, output logic [DATAW-1:0] d);
    rd = 1'b1; addr = a;
    step();
    rd = 1'b0;
    d = rdata;
  endtask

  logic [DATAW-1:0] v;

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_leds", 32'(leds), 32'h0);
    bus_read(simplez_pkg::ADDR_TXSTAT, v);
    check("reset_status", 32'(v), 32'h001);

    // RAM
    bus_write(9'd17, 12'h5A3);
    bus_write(9'd18, 12'h000);
    bus_read(9'd17, v);
    check("ram_rd17", 32'(v), 32'h5A3);
    bus_read(9'd507, v);
    bus_write(9'd507, 12'hABC);
    bus_read(9'd507, v);
    check("ram_rd507", 32'(v), 32'hABC);
    bus_read(9'd18, v);
    check("ram_rd18", 32'(v), 32'h000);

    // Reserved slot
    bus_write(simplez_pkg::ADDR_RSVD, 12'hFFF);
    bus_read(simplez_pkg::ADDR_RSVD, v);
    check("rsvd_rd", 32'(v), 32'h000);

    // LED register
    bus_write(simplez_pkg::ADDR_LEDS, 12'h006);
    check("leds_after_wr", 32'(leds), 32'h6);
    bus_read(simplez_pkg::ADDR_LEDS, v);
    check("leds_rd", 32'(v), 32'h006);
    bus_write(simplez_pkg::ADDR_LEDS, 12'hFF1);
    check("leds_trunc", 32'(leds), 32'h1);
    bus_read(simplez_pkg::ADDR_LEDS, v);
    check("leds_rd_trunc", 32'(v), 32'h001);
    bus_read(9'd507, v);
    check("io_no_ram", 32'(v), 32'hABC);

    // Simultaneous rd+wr: write wins, rdata holds
    bus_read(9'd17, v);
    rd = 1'b1; wr = 1'b1; addr = 9'd20; wdata = 12'h123;
    step();
    rd = 1'b0; wr = 1'b0;
    check("rdwr_hold", 32'(rdata), 32'h5A3);
    bus_read(9'd20, v);
    check("rdwr_ram20", 32'(v), 32'h123);

    // Serial frame with an overrun attempt in the middle
    bus_write(simplez_pkg::ADDR_TXDATA, 12'h141);
    for (int i = 0; i < FRAME_BITS * BAUD; i++) begin
      if (tx !== WAVE_41[i / BAUD]) begin
        check($sformatf("tx_cyc%0d", i), 32'(tx), 32'(WAVE_41[i / BAUD]));
      end else if (i % BAUD == 0) begin
        check($sformatf("tx_bit%0d", i / BAUD), 32'(tx), 32'(WAVE_41[i / BAUD]));
      end
      if (i == FRAME_BITS * BAUD - 1) check("ready_last_cyc", 32'(dut.tx_ready), 32'h0);
      wr = 1'b0; rd = 1'b0;
      if (i == 10) begin wr = 1'b1; addr = simplez_pkg::ADDR_TXDATA; wdata = 12'h055; end
      if (i == 12) begin rd = 1'b1; addr = simplez_pkg::ADDR_TXSTAT; end
      step();
      if (i == 12) check("stat_overrun", 32'(rdata), 32'h002);
    end
    wr = 1'b0; rd = 1'b0;
    check("ready_after_frame", 32'(dut.tx_ready), 32'h1);
    check("tx_idle", 32'(tx), 32'h1);
    bus_read(simplez_pkg::ADDR_TXSTAT, v);
    check("stat_after", 32'(v), 32'h001);
    bus_read(simplez_pkg::ADDR_TXDATA, v);
    check("txdata_rd", 32'(v), 32'h041);

    // Reset in the middle of a frame
    bus_write(simplez_pkg::ADDR_TXDATA, 12'h000);
    bus_write(simplez_pkg::ADDR_TXDATA, 12'h0AA);
    for (int i = 1; i < 15; i++) step();
    check("tx_mid_frame", 32'(tx), 32'h0);
    rst = 1'b1;
    step();
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    rst = 1'b0;
    bus_read(simplez_pkg::ADDR_TXSTAT, v);
    check("rst_status", 32'(v), 32'h001);
    step();
    check("rst_tx_stays", 32'(tx), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
